// File: rtl/control_sequencer_if.sv
// Memory bus between the control sequencer (master) and instruction/data memory (slave).
interface control_sequencer_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W+1:0] instr;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    input  instr,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    output instr,
    output mem_ready
  );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for a four-opcode accumulator machine.
// Drives a single shared memory port for both instruction fetch and operand access.
module control_sequencer #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  control_sequencer_if.master bus,
  output logic [ADDR_W-1:0] pc_o,
  output logic [1:0]        ir_op,
  output logic [ADDR_W-1:0] ir_operand,
  output logic              acc_load,
  output logic              alu_add,
  output logic              busy,
  output logic [2:0]        state_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;

  localparam logic [1:0] OpAdd   = 2'b00;
  localparam logic [1:0] OpJump  = 2'b01;
  localparam logic [1:0] OpLoad  = 2'b10;
  localparam logic [1:0] OpStore = 2'b11;

  localparam logic [ADDR_W-1:0] PcOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] operand_q, operand_d;
  logic [2:0]        next_instr_state;

  // End of an instruction: halt is only honoured here, never mid-access.
  always_comb begin
    next_instr_state = halt_req ? StIdle : StFetch;
  end

  // Next-state logic for the FSM, program counter and instruction register.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    operand_d = operand_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (bus.mem_ready) begin
          op_d      = bus.instr[ADDR_W+1:ADDR_W];
          operand_d = bus.instr[ADDR_W-1:0];
          pc_d      = pc_q + PcOne;  // wraps naturally modulo 2^ADDR_W
          state_d   = StDecode;
        end
      end
      StDecode: begin
        if (op_q == OpJump) begin
          pc_d    = operand_q;
          state_d = next_instr_state;
        end else begin
          state_d = StMem;
        end
      end
      StMem: begin
        if (bus.mem_ready) begin
          state_d = (op_q == OpStore) ? next_instr_state : StWb;
        end
      end
      StWb: begin
        state_d = next_instr_state;
      end
      default: begin
        // Unused encodings recover to idle.
        state_d = StIdle;
      end
    endcase
  end

  // State registers; async reset clears everything so mem_req drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      op_q      <= OpAdd;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      operand_q <= operand_d;
    end
  end

  // Outputs decoded purely from registered state, so they are stable through memory waits.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    acc_load     = 1'b0;
    alu_add      = 1'b0;
    case (state_q)
      StFetch: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = pc_q;
      end
      StMem: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = (op_q == OpStore);
        bus.mem_addr = operand_q;
      end
      StWb: begin
        acc_load = 1'b1;
        alu_add  = (op_q == OpAdd);
      end
      default: begin
        bus.mem_req = 1'b0;
      end
    endcase
  end

  assign pc_o       = pc_q;
  assign ir_op      = op_q;
  assign ir_operand = operand_q;
  assign busy       = (state_q != StIdle);
  assign state_o    = state_q;

  // OpLoad needs no special handling beyond the default MEM->WB path.
  logic unused_op_load;
  assign unused_op_load = (op_q == OpLoad);

endmodule
